// File: rtl/bresenham_scan_sequencer_pkg.sv
// Shared types and constants for the scan sequencer.
//   COORD_W      grid coordinate width, matches the ray unit x/y ports
//   seq_state_t  sequencer FSM state encoding
package bresenham_scan_sequencer_pkg;

  localparam int COORD_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    ISSUE,
    WAIT_RAY,
    NEXT,
    DONE
  } seq_state_t;

endpackage

// File: rtl/bresenham_scan_sequencer_ray_watchdog.sv
// Per-ray watchdog: counts cycles spent on one ray and flags expiry once
// TIMEOUT_CYCLES enabled cycles have elapsed since the last clear.
// Ports:
//   i_clock, i_reset  clock, synchronous active-high reset
//   i_clear           restart the count
//   i_enable          count this cycle
//   o_expired         high on the TIMEOUT_CYCLES-th enabled cycle
module ray_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The count holds at LAST, so expiry stays asserted until the FSM leaves.
  assign o_expired = i_enable && (r_cnt == LAST);

endmodule

// File: rtl/bresenham_scan_sequencer.sv
// Walks one laser scan out of beam RAM and hands each valid endpoint to the
// Bresenham ray unit, one ray at a time, with abort and per-ray watchdog.
// Ports:
//   i_clock, i_reset                 clock, synchronous active-high reset
//   i_scan_start, i_scan_abort       scan control pulses
//   o_beam_rd_en, o_beam_addr        beam RAM read port
//   i_beam_x, i_beam_y, i_beam_valid beam RAM data, one cycle after read
//   o_ray_start, o_ray_x/y_end       ray unit request and endpoint
//   i_ray_busy, i_occupancy_busy     downstream busy flags
//   o_scan_busy, o_scan_done, o_scan_aborted, o_timeout_error  status
//   o_beams_done, o_beams_skipped    per-scan counters
//
// state    | meaning
// IDLE     | waiting for scan_start
// FETCH    | read strobe for beam at idx
// LOAD     | capture endpoint, skip if invalid
// ISSUE    | request ray once ray unit and occupancy map are idle
// WAIT_RAY | ray in flight, wait for ray unit to go idle
// NEXT     | advance idx or finish
// DONE     | one-cycle completion pulse
module bresenham_scan_sequencer #(
  parameter int N_BEAMS        = 64,
  parameter int IDX_W          = $clog2(N_BEAMS),
  parameter int COORD_W        = bresenham_scan_sequencer_pkg::COORD_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_scan_start,
  input  logic               i_scan_abort,
  output logic               o_beam_rd_en,
  output logic [IDX_W-1:0]   o_beam_addr,
  input  logic [COORD_W-1:0] i_beam_x,
  input  logic [COORD_W-1:0] i_beam_y,
  input  logic               i_beam_valid,
  output logic               o_ray_start,
  output logic [COORD_W-1:0] o_ray_x_end,
  output logic [COORD_W-1:0] o_ray_y_end,
  input  logic               i_ray_busy,
  input  logic               i_occupancy_busy,
  output logic               o_scan_busy,
  output logic               o_scan_done,
  output logic               o_scan_aborted,
  output logic               o_timeout_error,
  output logic [IDX_W:0]     o_beams_done,
  output logic [IDX_W:0]     o_beams_skipped
);

  import bresenham_scan_sequencer_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BEAMS - 1);

  seq_state_t         r_state;
  seq_state_t         w_next_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_abort_pending;
  logic               r_ray_start;
  logic               r_timeout_error;
  logic [COORD_W-1:0] r_ray_x_end;
  logic [COORD_W-1:0] r_ray_y_end;
  logic [IDX_W:0]     r_beams_done;
  logic [IDX_W:0]     r_beams_skipped;
  logic               w_wd_enable;
  logic               w_wd_clear;
  logic               w_wd_expired;
  logic               w_accept;

  assign w_wd_enable = (r_state == ISSUE) || (r_state == WAIT_RAY);
  assign w_wd_clear  = !w_wd_enable;
  assign w_accept    = (r_state == IDLE) && i_scan_start && !i_scan_abort;

  ray_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_ray_watchdog (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (w_wd_clear),
    .i_enable (w_wd_enable),
    .o_expired(w_wd_expired)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state    = r_state;
    o_beam_rd_en    = 1'b0;
    o_scan_busy     = (r_state != IDLE);
    o_scan_done     = 1'b0;
    o_scan_aborted  = 1'b0;
    case (r_state)
      IDLE:     if (w_accept) w_next_state = FETCH;
      FETCH: begin
        o_beam_rd_en = 1'b1;
        w_next_state = LOAD;
      end
      LOAD: begin
        if (!i_beam_valid)        w_next_state = NEXT;
        else if (r_abort_pending) w_next_state = DONE;
        else                      w_next_state = ISSUE;
      end
      // Once ray_busy is seen the ray is committed and must be waited out.
      ISSUE: begin
        if (w_wd_expired)         w_next_state = DONE;
        else if (i_ray_busy)      w_next_state = WAIT_RAY;
        else if (r_abort_pending) w_next_state = DONE;
      end
      WAIT_RAY: begin
        if (w_wd_expired)         w_next_state = DONE;
        else if (!i_ray_busy)     w_next_state = NEXT;
      end
      NEXT: begin
        if ((r_idx == LAST_IDX) || r_abort_pending) w_next_state = DONE;
        else                                        w_next_state = FETCH;
      end
      DONE: begin
        o_scan_done    = 1'b1;
        o_scan_aborted = r_abort_pending;
        w_next_state   = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_idx           <= '0;
      r_abort_pending <= 1'b0;
      r_ray_start     <= 1'b0;
      r_timeout_error <= 1'b0;
      r_ray_x_end     <= '0;
      r_ray_y_end     <= '0;
      r_beams_done    <= '0;
      r_beams_skipped <= '0;
    end else begin
      // Registered request: a change in the busy inputs shows on ray_start
      // one cycle later, and a pending abort stops any new request.
      r_ray_start <= (w_next_state == ISSUE) && !i_ray_busy && !i_occupancy_busy
                     && !r_abort_pending && !i_scan_abort;

      if (w_accept) begin
        r_idx           <= '0;
        r_timeout_error <= 1'b0;
        r_beams_done    <= '0;
        r_beams_skipped <= '0;
      end

      if (r_state == DONE) begin
        r_abort_pending <= 1'b0;
        r_idx           <= '0;
      end else if (r_state != IDLE) begin
        if (i_scan_abort) r_abort_pending <= 1'b1;
        // A watchdog expiry ends the scan as an abort.
        if (w_wd_expired) begin
          r_abort_pending <= 1'b1;
          r_timeout_error <= 1'b1;
        end
      end

      if (r_state == LOAD) begin
        r_ray_x_end <= i_beam_x;
        r_ray_y_end <= i_beam_y;
        if (!i_beam_valid) r_beams_skipped <= r_beams_skipped + 1'b1;
      end

      if ((r_state == WAIT_RAY) && !w_wd_expired && !i_ray_busy)
        r_beams_done <= r_beams_done + 1'b1;

      if ((r_state == NEXT) && (w_next_state == FETCH))
        r_idx <= r_idx + 1'b1;
    end
  end

  assign o_beam_addr     = r_idx;
  assign o_ray_start     = r_ray_start;
  assign o_ray_x_end     = r_ray_x_end;
  assign o_ray_y_end     = r_ray_y_end;
  assign o_timeout_error = r_timeout_error;
  assign o_beams_done    = r_beams_done;
  assign o_beams_skipped = r_beams_skipped;

endmodule

// File: tb/tb_bresenham_scan_sequencer.sv
// Testbench for bresenham_scan_sequencer: beam RAM and ray unit models,
// randomized endpoints/valid masks checked against a per-scan expectation.
module tb_bresenham_scan_sequencer;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int CW = 5;
  localparam int TO = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          scan_start = 1'b0;
  logic          scan_abort = 1'b0;
  logic          beam_rd_en;
  logic [IW-1:0] beam_addr;
  logic [CW-1:0] beam_x = '0;
  logic [CW-1:0] beam_y = '0;
  logic          beam_valid = 1'b0;
  logic          ray_start;
  logic [CW-1:0] ray_x_end, ray_y_end;
  logic          ray_busy = 1'b0;
  logic          occupancy_busy = 1'b0;
  logic          scan_busy, scan_done, scan_aborted, timeout_error;
  logic [IW:0]   beams_done, beams_skipped;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  bresenham_scan_sequencer #(
    .N_BEAMS(N), .IDX_W(IW), .COORD_W(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clock(clock), .i_reset(reset),
    .i_scan_start(scan_start), .i_scan_abort(scan_abort),
    .o_beam_rd_en(beam_rd_en), .o_beam_addr(beam_addr),
    .i_beam_x(beam_x), .i_beam_y(beam_y), .i_beam_valid(beam_valid),
    .o_ray_start(ray_start), .o_ray_x_end(ray_x_end), .o_ray_y_end(ray_y_end),
    .i_ray_busy(ray_busy), .i_occupancy_busy(occupancy_busy),
    .o_scan_busy(scan_busy), .o_scan_done(scan_done),
    .o_scan_aborted(scan_aborted), .o_timeout_error(timeout_error),
    .o_beams_done(beams_done), .o_beams_skipped(beams_skipped)
  );

  // Beam RAM: registered read.
  logic [CW-1:0] mem_x [N];
  logic [CW-1:0] mem_y [N];
  logic          mem_v [N];

  always @(posedge clock) begin
    if (beam_rd_en) begin
      beam_x     <= mem_x[beam_addr];
      beam_y     <= mem_y[beam_addr];
      beam_valid <= mem_v[beam_addr];
    end
  end

  // Ray unit model plus monitor, both on the falling edge.
  int ray_len   = 3;
  bit ray_never = 0;
  int ray_cnt   = 0;
  int done_cnt  = 0;
  int start_hi  = 0;
  logic [2*CW-1:0] hs_q[$];
  int              fetch_q[$];
  logic        last_aborted, last_timeout;
  logic [IW:0] last_done, last_skip;

  always @(negedge clock) begin
    if (!reset) begin
      if (scan_done) begin
        done_cnt++;
        last_aborted = scan_aborted;
        last_timeout = timeout_error;
        last_done    = beams_done;
        last_skip    = beams_skipped;
      end
      if (beam_rd_en) fetch_q.push_back(int'(beam_addr));
      if (ray_start) start_hi++;
    end
    if (ray_busy) begin
      ray_cnt--;
      if (ray_cnt <= 0) ray_busy = 1'b0;
    end else if (ray_start && !ray_never) begin
      hs_q.push_back({ray_x_end, ray_y_end});
      ray_busy = 1'b1;
      ray_cnt  = ray_len;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_mon();
    hs_q.delete();
    fetch_q.delete();
    start_hi = 0;
  endtask

  task automatic fill_mem(input logic [N-1:0] valid_mask);
    for (int a = 0; a < N; a++) begin
      mem_x[a] = CW'($urandom_range(0, 31));
      mem_y[a] = CW'($urandom_range(0, 31));
      mem_v[a] = valid_mask[a];
    end
  endtask

  task automatic start_pulse();
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
  endtask

  task automatic wait_done(input int prev, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cnt != prev) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_hs(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (hs_q.size() >= n) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_ray_idle();
    for (int i = 0; i < 50 && ray_busy; i++) tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({beam_rd_en, beam_addr, ray_start, ray_x_end, ray_y_end, scan_busy, scan_done,
         scan_aborted, timeout_error, beams_done, beams_skipped} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: outputs not all zero (busy=%0b addr=%0d done=%0d)",
               scan_busy, beam_addr, beams_done);
    end
    tick();
  endtask

  // Full scan with a random valid mask; expectation built from the RAM contents.
  task automatic test_scan(input string name, input logic [N-1:0] mask, input int len,
                           input bit poke_start);
    logic [2*CW-1:0] exp_q[$];
    int  prev, n_valid;
    bit  ok;
    fill_mem(mask);
    exp_q.delete();
    n_valid = 0;
    for (int a = 0; a < N; a++)
      if (mem_v[a]) begin
        exp_q.push_back({mem_x[a], mem_y[a]});
        n_valid++;
      end
    ray_len = len;
    clear_mon();
    prev = done_cnt;
    start_pulse();
    if (poke_start) begin
      tick();
      start_pulse();   // must be ignored while busy
    end
    wait_done(prev, 400, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_done_seen: no scan_done within budget", name);
    end
    wait_ray_idle();
    tick();
    n_checks++;
    if (done_cnt != prev + 1) begin
      n_fail++;
      $display("FAIL %s_done_count: got %0d pulses, expected 1", name, done_cnt - prev);
    end
    n_checks++;
    if (hs_q.size() != n_valid) begin
      n_fail++;
      $display("FAIL %s_handshakes: got %0d, expected %0d", name, hs_q.size(), n_valid);
    end
    for (int i = 0; i < n_valid && i < hs_q.size(); i++) begin
      n_checks++;
      if (hs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s_endpoint%0d: got %h, expected %h", name, i, hs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (last_done !== (IW + 1)'(n_valid) || last_skip !== (IW + 1)'(N - n_valid)) begin
      n_fail++;
      $display("FAIL %s_counters: done=%0d skipped=%0d, expected %0d/%0d",
               name, last_done, last_skip, n_valid, N - n_valid);
    end
    n_checks++;
    if (last_aborted !== 1'b0 || last_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_status: aborted=%0b timeout=%0b, expected 0/0",
               name, last_aborted, last_timeout);
    end
    n_checks++;
    if (fetch_q.size() != N) begin
      n_fail++;
      $display("FAIL %s_fetches: got %0d reads, expected %0d", name, fetch_q.size(), N);
    end else begin
      for (int a = 0; a < N; a++) begin
        n_checks++;
        if (fetch_q[a] != a) begin
          n_fail++;
          $display("FAIL %s_fetch_addr%0d: got %0d, expected %0d", name, a, fetch_q[a], a);
        end
      end
    end
  endtask

  task automatic test_random_scans();
    for (int it = 0; it < 6; it++)
      test_scan("random", N'($urandom_range(0, 15)), $urandom_range(1, 5), 1'b0);
  endtask

  task automatic test_back_to_back();
    test_scan("b2b_first", 4'b1111, 2, 1'b0);
    test_scan("b2b_second", 4'b0101, 1, 1'b0);
  endtask

  task automatic test_occupancy();
    int prev;
    bit ok;
    fill_mem(4'b1111);
    ray_len = 2;
    clear_mon();
    prev = done_cnt;
    occupancy_busy = 1'b1;
    start_pulse();          // now in FETCH
    tick();                 // LOAD
    tick();                 // ISSUE, first cycle
    repeat (9) tick();      // ISSUE, tenth cycle
    tick();
    occupancy_busy = 1'b0;
    @(negedge clock);
    n_checks++;
    if (start_hi != 0 || ray_start !== 1'b0) begin
      n_fail++;
      $display("FAIL occ_gate: ray_start seen %0d cycles while occupancy busy", start_hi);
    end
    @(negedge clock);
    n_checks++;
    if (ray_start !== 1'b1) begin
      n_fail++;
      $display("FAIL occ_release: ray_start=%0b cycle after drop, expected 1", ray_start);
    end
    wait_done(prev, 200, ok);
    wait_ray_idle();
    n_checks++;
    if (!ok || last_done !== 3'd4 || hs_q.size() != 4) begin
      n_fail++;
      $display("FAIL occ_complete: done_seen=%0b beams_done=%0d rays=%0d, expected 1/4/4",
               ok, last_done, hs_q.size());
    end
  endtask

  task automatic test_abort();
    int prev;
    bit ok;
    fill_mem(4'b1111);
    ray_len = 6;
    clear_mon();
    prev = done_cnt;
    start_pulse();
    wait_hs(2, 100, ok);
    tick();                 // beam 1 now in WAIT_RAY
    scan_abort = 1'b1;
    tick();
    scan_abort = 1'b0;
    wait_done(prev, 100, ok);
    wait_ray_idle();
    n_checks++;
    if (!ok || last_aborted !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_flag: done_seen=%0b aborted=%0b, expected 1/1", ok, last_aborted);
    end
    n_checks++;
    if (last_done !== 3'd2 || hs_q.size() != 2) begin
      n_fail++;
      $display("FAIL abort_count: beams_done=%0d rays=%0d, expected 2/2", last_done, hs_q.size());
    end
    n_checks++;
    if (fetch_q.size() != 2) begin
      n_fail++;
      $display("FAIL abort_no_fetch: got %0d reads, expected 2", fetch_q.size());
    end
  endtask

  task automatic test_timeout();
    int prev;
    bit ok;
    fill_mem(4'b1111);
    ray_never = 1;
    clear_mon();
    prev = done_cnt;
    start_pulse();
    wait_done(prev, 100, ok);
    n_checks++;
    if (!ok || last_timeout !== 1'b1 || last_aborted !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_flag: done_seen=%0b timeout=%0b aborted=%0b, expected 1/1/1",
               ok, last_timeout, last_aborted);
    end
    n_checks++;
    if (start_hi != TO || last_done !== 3'd0) begin
      n_fail++;
      $display("FAIL timeout_length: ray_start cycles=%0d beams_done=%0d, expected %0d/0",
               start_hi, last_done, TO);
    end
    ray_never = 0;
    repeat (5) tick();
    n_checks++;
    if (timeout_error !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_sticky: got %0b, expected 1", timeout_error);
    end
    clear_mon();
    scan_start = 1'b1;
    scan_abort = 1'b1;
    tick();
    scan_start = 1'b0;
    scan_abort = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (scan_busy !== 1'b0 || fetch_q.size() != 0 || timeout_error !== 1'b1) begin
      n_fail++;
      $display("FAIL start_abort_same_cycle: busy=%0b reads=%0d timeout=%0b, expected 0/0/1",
               scan_busy, fetch_q.size(), timeout_error);
    end
    prev = done_cnt;
    start_pulse();
    @(negedge clock);
    n_checks++;
    if (timeout_error !== 1'b0 || scan_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_clear: timeout=%0b busy=%0b, expected 0/1", timeout_error, scan_busy);
    end
    wait_done(prev, 200, ok);
    wait_ray_idle();
  endtask

  task automatic test_reset_mid_scan();
    int prev;
    bit ok;
    fill_mem(4'b1111);
    ray_len = 6;
    clear_mon();
    prev = done_cnt;
    start_pulse();
    wait_hs(1, 100, ok);
    tick();
    tick();                 // WAIT_RAY
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if (!ok || {beam_rd_en, beam_addr, ray_start, ray_x_end, ray_y_end, scan_busy, scan_done,
                scan_aborted, timeout_error, beams_done, beams_skipped} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: busy=%0b x=%0d done=%0d, expected all zero",
               scan_busy, ray_x_end, beams_done);
    end
    repeat (10) tick();
    n_checks++;
    if (done_cnt != prev || scan_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: pulses=%0d busy=%0b, expected 0/0",
               done_cnt - prev, scan_busy);
    end
    wait_ray_idle();
  endtask

  initial begin
    test_reset();
    test_scan("all_valid", 4'b1111, 3, 1'b1);
    test_scan("skip_1_2", 4'b1001, 3, 1'b0);
    test_random_scans();
    test_back_to_back();
    test_occupancy();
    test_abort();
    test_timeout();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

endmodule
